// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolver: per-stage prediction metadata
// and the sequential-fetch PC increment.
package br_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic            valid;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } br_meta_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/execute-side signal bundle of the branch resolver; the slave modport is the resolver.
interface branch_resolver_if;
    import br_pkg::*;

    logic            i_stall;
    logic            i_valid_if;
    logic            i_pred_taken_if;
    logic [XLEN-1:0] i_pred_target_if;
    logic [XLEN-1:0] i_pc_ex;
    logic            i_is_ctrl_ex;
    logic            i_actual_taken;
    logic [XLEN-1:0] i_target_addr;

    logic            o_redirect;
    logic [XLEN-1:0] o_redirect_pc;
    logic            o_flush;
    logic            o_train_valid;
    logic [XLEN-1:0] o_train_pc;
    logic            o_train_taken;
    logic [XLEN-1:0] o_train_target;

    modport master (
        output i_stall, i_valid_if, i_pred_taken_if, i_pred_target_if,
               i_pc_ex, i_is_ctrl_ex, i_actual_taken, i_target_addr,
        input  o_redirect, o_redirect_pc, o_flush,
               o_train_valid, o_train_pc, o_train_taken, o_train_target
    );

    modport slave (
        input  i_stall, i_valid_if, i_pred_taken_if, i_pred_target_if,
               i_pc_ex, i_is_ctrl_ex, i_actual_taken, i_target_addr,
        output o_redirect, o_redirect_pc, o_flush,
               o_train_valid, o_train_pc, o_train_taken, o_train_target
    );

endinterface

// File: rtl/br_meta_pipe.sv
// Carries prediction metadata from IF through ID to EX, honouring stall and flush.
module br_meta_pipe
    import br_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_stall,
    input  logic     i_flush,
    input  br_meta_t i_if_meta,
    output br_meta_t o_ex_meta
);

    br_meta_t id_q;
    br_meta_t ex_q;

    // Flush wins over advance; a stalled pipe holds everything.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (i_flush) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (!i_stall) begin
            id_q <= i_if_meta;
            ex_q <= id_q;
        end
    end

    assign o_ex_meta = ex_q;

endmodule

// File: rtl/branch_resolver.sv
// Compares the EX-stage branch outcome with its prediction, redirects/flushes fetch and
// trains the predictor. Optional performance counters under macro BR_PERF_CNT_EN.
module branch_resolver
    import br_pkg::*;
`ifdef BR_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic              i_clk,
    input  logic              i_reset,
`ifdef BR_PERF_CNT_EN
    output logic [CNT_W-1:0]  o_branch_cnt,
    output logic [CNT_W-1:0]  o_mispred_cnt,
`endif
    branch_resolver_if.slave  bus
);

    br_meta_t if_meta;
    br_meta_t ex_meta;
    logic     ex_ctrl_taken;
    logic     mispredict;
    logic     redirect;
    logic     train_valid;

    assign if_meta = '{valid:       bus.i_valid_if,
                       pred_taken:  bus.i_pred_taken_if,
                       pred_target: bus.i_pred_target_if};

    br_meta_pipe u_meta (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_stall   (bus.i_stall),
        .i_flush   (redirect),
        .i_if_meta (if_meta),
        .o_ex_meta (ex_meta)
    );

    // A non-control instruction predicted taken is a BTB alias and must fall through.
    always_comb begin
        ex_ctrl_taken = bus.i_is_ctrl_ex & bus.i_actual_taken;
        mispredict    = ex_meta.valid &
                        ((bus.i_is_ctrl_ex &
                          ((bus.i_actual_taken != ex_meta.pred_taken) |
                           (bus.i_actual_taken & (ex_meta.pred_target != bus.i_target_addr)))) |
                         (~bus.i_is_ctrl_ex & ex_meta.pred_taken));
        redirect      = mispredict & ~bus.i_stall;
        train_valid   = ex_meta.valid & bus.i_is_ctrl_ex & ~bus.i_stall;
    end

    // Data outputs are zeroed for an empty EX slot so a reset or bubble drives all-zero.
    always_comb begin
        bus.o_redirect     = redirect;
        bus.o_flush        = redirect;
        bus.o_train_valid  = train_valid;
        bus.o_redirect_pc  = '0;
        bus.o_train_pc     = '0;
        bus.o_train_taken  = 1'b0;
        bus.o_train_target = '0;
        if (ex_meta.valid) begin
            bus.o_redirect_pc  = ex_ctrl_taken ? bus.i_target_addr : bus.i_pc_ex + PC_STEP;
            bus.o_train_pc     = bus.i_pc_ex;
            bus.o_train_taken  = bus.i_actual_taken;
            bus.o_train_target = bus.i_target_addr;
        end
    end

`ifdef BR_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_branch_cnt  <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (train_valid && (o_branch_cnt != '1)) begin
                o_branch_cnt <= o_branch_cnt + CNT_W'(1);
            end
            if (redirect && (o_mispred_cnt != '1)) begin
                o_mispred_cnt <= o_mispred_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter CNT_W, default 32: width of the performance counters.
REQ-002 i_clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 i_reset  in  1  asynchronous, active-low reset.
REQ-004 i_stall  in  1  pipeline hold; all metadata registers keep their values.
REQ-005 i_valid_if  in  1  the fetch slot holds a real instruction.
REQ-006 i_pred_taken_if / i_pred_target_if  in  1/32  predictor output for the instruction in IF.
REQ-007 i_pc_ex / i_is_ctrl_ex  in  32/1  EX-stage PC; the EX instruction is a branch or jump.
REQ-008 i_actual_taken / i_target_addr  in  1/32  resolved outcome and target from EX.
REQ-009 o_redirect / o_redirect_pc  out  1/32  fetch redirect request and correct PC.
REQ-010 o_flush  out  1  squash the IF/ID and ID/EX pipeline registers.
REQ-011 o_train_valid / o_train_pc / o_train_taken / o_train_target  out  1/32/1/32  predictor training port.
REQ-012 o_branch_cnt / o_mispred_cnt  out  CNT_W each  performance counters; present only under the macro defined in REQ-025.

Function
REQ-013 Two metadata stages, ID and EX, SHALL each hold {valid, pred_taken, pred_target}; IF->ID->EX advance one stage per cycle when i_stall=0.
REQ-014 mispredict SHALL be EX.valid & ((i_is_ctrl_ex & (i_actual_taken != EX.pred_taken | (i_actual_taken & EX.pred_target != i_target_addr))) | (~i_is_ctrl_ex & EX.pred_taken)).
REQ-015 o_redirect SHALL equal mispredict & ~i_stall, combinationally, in the same cycle EX resolves (0 extra latency).
REQ-016 o_redirect_pc SHALL be i_target_addr when i_is_ctrl_ex & i_actual_taken, otherwise i_pc_ex+4 (modulo 2^32, so 0xFFFFFFFC wraps to 0x0); its value is don't-care while o_redirect=0.
REQ-017 o_flush SHALL equal o_redirect.
REQ-018 On a rising edge with o_flush=1, ID.valid and EX.valid SHALL become 0 and both pred_taken bits 0; flush overrides the normal advance.
REQ-019 o_train_valid SHALL be EX.valid & i_is_ctrl_ex & ~i_stall; o_train_pc, o_train_taken and o_train_target SHALL pass through i_pc_ex, i_actual_taken and i_target_addr.
REQ-020 A non-control instruction predicted taken (BTB alias) SHALL redirect to i_pc_ex+4 and SHALL NOT train.
REQ-021 While i_stall=1, o_redirect, o_flush and o_train_valid SHALL be 0; resolution is deferred to the first cycle with i_stall=0.
REQ-022 An invalid EX slot (bubble or flushed) SHALL never redirect or train, whatever the values of the i_*_ex inputs.

Reset
REQ-023 While i_reset=0, all metadata registers SHALL clear (valid=0, pred_taken=0, pred_target=0) and the counters SHALL clear to 0; all outputs SHALL be 0.
REQ-024 If reset asserts mid-operation, any in-flight mispredict SHALL be dropped, and no redirect SHALL occur until a new valid instruction reaches EX.

Configuration
REQ-025 Macro BR_PERF_CNT_EN, when defined: o_branch_cnt SHALL increment on each o_train_valid, and o_mispred_cnt SHALL increment on each o_redirect; both saturate at all-ones. When undefined, the counters and their ports SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package br_pkg SHALL hold the typedef br_meta_t {valid, pred_taken, pred_target[31:0]} and the constant PC_STEP=4.
REQ-027 The two-stage metadata pipe SHALL be the sub-module br_meta_pipe (stall, flush, reset); the compare/redirect logic stays in branch_resolver.

Verification
REQ-028 Predicted not-taken, resolved taken to 0x100 at PC 0x40 -> o_redirect=1, o_redirect_pc=0x100, o_train_valid=1, o_train_taken=1; the next cycle ID.valid=EX.valid=0.
REQ-029 Predicted taken to 0x80, resolved taken to 0x90 -> redirect to 0x90; predicted taken to 0x90, resolved 0x90 -> o_redirect=0, o_train_valid=1.
REQ-030 Predicted taken, resolved not-taken at PC 0xFFFFFFFC -> o_redirect_pc=0x00000000.
REQ-031 Mispredict present with i_stall=1 for 3 cycles -> o_redirect=0 for those 3 cycles, and 1 in the cycle i_stall drops; the metadata is held throughout.
REQ-032 Non-control instruction with EX.pred_taken=1 at PC 0x20 -> redirect to 0x24, o_train_valid=0; the same stimulus with EX.valid=0 -> no outputs.
REQ-033 With BR_PERF_CNT_EN defined: 5 branches including 2 mispredicts -> o_branch_cnt=5, o_mispred_cnt=2; i_reset=0 mid-sequence -> both counters 0 immediately.
